// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the parallel-bus DAC writer
// Contents: dac_state_t FSM encoding, LDAC mode selectors, default bus sizes.

package dac_pkg;

    localparam int LDAC_MODE_SIMUL = 0;
    localparam int LDAC_MODE_IMMED = 1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;

    typedef enum logic [3:0] {
        S_OFF,
        S_INIT,
        S_READY,
        S_CLEAR,
        S_CS_LO,
        S_WR_LO,
        S_WR_HI,
        S_CS_HI,
        S_LDAC_P,
        S_FINISH
    } dac_state_t;

endpackage

// File: rtl/dac_mask_sel.sv
// rtl/dac_mask_sel.sv - lowest-set-bit priority encoder for channel selection
// Ports:
//   mask : channel mask to search
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : high when any mask bit is set

module dac_mask_sel #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 2
) (
    input  logic [NUM_CH-1:0] mask,
    output logic [ADDR_W-1:0] idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/dac_par_writer.sv
// rtl/dac_par_writer.sv - parametrised parallel-bus multi-channel DAC writer
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   ch_data, ch_mask : per-channel samples and write mask, captured on start
//   start, clear     : transaction / CLR-pulse requests, honoured only in READY
//   pwr              : 1 powers the DAC up, 0 powers it down
//   gain             : passed straight through to GAIN
//   ready, done      : idle indication and end-of-transaction pulse
//   CS, WR, LDAC, CLR, PD, ADDR, DATA, GAIN : registered DAC pins (GAIN is not)

module dac_par_writer
    import dac_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ADDR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int WR_CYC    = 1,
    parameter int LDAC_MODE = LDAC_MODE_SIMUL,
    parameter int LDAC_CYC  = 1,
    parameter int CLR_CYC   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     start,
    input  logic                     pwr,
    input  logic                     clear,
    input  logic                     gain,
    output logic                     ready,
    output logic                     done,
    output logic                     CS,
    output logic                     WR,
    output logic                     LDAC,
    output logic                     CLR,
    output logic                     PD,
    output logic                     GAIN,
    output logic [ADDR_W-1:0]        ADDR,
    output logic [DATA_W-1:0]        DATA
);

    localparam int MAX_AB  = (WR_CYC > LDAC_CYC) ? WR_CYC : LDAC_CYC;
    localparam int MAX_CYC = (MAX_AB > CLR_CYC) ? MAX_AB : CLR_CYC;
    // The counter is loaded with CYC-1 and runs down to zero.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    dac_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [NUM_CH-1:0][DATA_W-1:0] cap_data;
    logic [NUM_CH-1:0]             cap_mask;
    logic [ADDR_W-1:0]             cur_ch;

    logic [NUM_CH-1:0] cur_bit;
    logic [NUM_CH-1:0] remaining;
    logic [NUM_CH-1:0] sel_in;
    logic [ADDR_W-1:0] sel_idx;
    logic              sel_any;

    assign cur_bit   = NUM_CH'(1) << cur_ch;
    assign remaining = cap_mask & ~cur_bit;
    // In READY the encoder looks at the live mask so the first channel is
    // known at the accept edge; afterwards it walks the captured remainder.
    assign sel_in    = (state == S_READY) ? ch_mask : remaining;

    dac_mask_sel #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_mask_sel (
        .mask (sel_in),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    assign GAIN = gain;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_OFF: begin
                if (pwr) begin
                    state_n = S_INIT;
                end
            end
            S_INIT: begin
                state_n = S_READY;
            end
            S_READY: begin
                if (start) begin
                    state_n = sel_any ? S_CS_LO : S_FINISH;
                end else if (!pwr) begin
                    state_n = S_OFF;
                end else if (clear) begin
                    state_n = S_CLEAR;
                    cnt_n   = CNT_W'(CLR_CYC - 1);
                end
            end
            S_CLEAR: begin
                if (cnt == '0) begin
                    state_n = S_READY;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_CS_LO: begin
                state_n = S_WR_LO;
                cnt_n   = CNT_W'(WR_CYC - 1);
            end
            S_WR_LO: begin
                if (cnt == '0) begin
                    state_n = S_WR_HI;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_WR_HI: begin
                state_n = S_CS_HI;
            end
            S_CS_HI: begin
                if (sel_any) begin
                    state_n = S_CS_LO;
                end else if (LDAC_MODE == LDAC_MODE_SIMUL) begin
                    state_n = S_LDAC_P;
                    cnt_n   = CNT_W'(LDAC_CYC - 1);
                end else begin
                    state_n = S_FINISH;
                end
            end
            S_LDAC_P: begin
                if (cnt == '0) begin
                    state_n = S_FINISH;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_n = S_READY;
            end
            default: begin
                state_n = S_OFF;
            end
        endcase
    end

    // Pins are decoded from the state being entered so that they change on
    // the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_OFF;
            cnt      <= '0;
            cap_data <= '0;
            cap_mask <= '0;
            cur_ch   <= '0;
            ready    <= 1'b0;
            done     <= 1'b0;
            CS       <= 1'b1;
            WR       <= 1'b1;
            LDAC     <= 1'b1;
            CLR      <= 1'b0;
            PD       <= 1'b0;
            ADDR     <= '0;
            DATA     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= (state_n == S_READY);
            done  <= (state_n == S_FINISH);
            CS    <= !((state_n == S_CS_LO) || (state_n == S_WR_LO) || (state_n == S_WR_HI));
            WR    <= (state_n != S_WR_LO);
            if (LDAC_MODE == LDAC_MODE_IMMED) begin
                LDAC <= (state_n == S_OFF);
            end else begin
                LDAC <= (state_n != S_LDAC_P);
            end
            CLR <= !((state_n == S_OFF) || (state_n == S_CLEAR));
            PD  <= (state_n != S_OFF);

            if ((state == S_READY) && start) begin
                cap_data <= ch_data;
                cap_mask <= ch_mask;
            end else if (state == S_CS_HI) begin
                cap_mask <= remaining;
            end

            if (state_n == S_CS_LO) begin
                cur_ch <= sel_idx;
                ADDR   <= sel_idx;
            end
            if (state_n == S_WR_LO) begin
                DATA <= cap_data[cur_ch];
            end
        end
    end

endmodule

// File: tb/tb_dac_par_writer.sv
// tb/tb_dac_par_writer.sv - scoreboard testbench for dac_par_writer (mode 0 and mode 1 instances)

module tb_dac_par_writer;

    typedef struct {
        int d;
        int addr;
        int data;
        int wlen;
    } wr_rec_t;

    typedef struct {
        int d;
        int lat;
        int cs_lo;
        int ldac_lo;
    } txn_rec_t;

    logic        clk;
    logic        reset;
    logic        gain;
    logic        start   [2];
    logic        pwr     [2];
    logic        clear   [2];
    logic [31:0] ch_data [2];
    logic [3:0]  ch_mask [2];
    logic        ready   [2];
    logic        done    [2];
    logic        cs      [2];
    logic        wr      [2];
    logic        ldac    [2];
    logic        clr     [2];
    logic        pd      [2];
    logic        gain_o  [2];
    logic [1:0]  addr    [2];
    logic [7:0]  data    [2];

    int checks = 0;
    int errors = 0;

    wr_rec_t  exp_wr[$];
    txn_rec_t exp_txn[$];

    bit active   [2];
    bit rdy_next [2];
    int since    [2];
    int wr_cnt   [2];
    int cs_cnt   [2];
    int ldac_cnt [2];

    dac_par_writer #(
        .DATA_W(8), .NUM_CH(4), .WR_CYC(1), .LDAC_MODE(0), .LDAC_CYC(1), .CLR_CYC(2)
    ) u_dut0 (
        .clk(clk), .reset(reset), .ch_data(ch_data[0]), .ch_mask(ch_mask[0]),
        .start(start[0]), .pwr(pwr[0]), .clear(clear[0]), .gain(gain),
        .ready(ready[0]), .done(done[0]), .CS(cs[0]), .WR(wr[0]), .LDAC(ldac[0]),
        .CLR(clr[0]), .PD(pd[0]), .GAIN(gain_o[0]), .ADDR(addr[0]), .DATA(data[0])
    );

    dac_par_writer #(
        .DATA_W(8), .NUM_CH(4), .WR_CYC(3), .LDAC_MODE(1), .LDAC_CYC(1), .CLR_CYC(2)
    ) u_dut1 (
        .clk(clk), .reset(reset), .ch_data(ch_data[1]), .ch_mask(ch_mask[1]),
        .start(start[1]), .pwr(pwr[1]), .clear(clear[1]), .gain(gain),
        .ready(ready[1]), .done(done[1]), .CS(cs[1]), .WR(wr[1]), .LDAC(ldac[1]),
        .CLR(clr[1]), .PD(pd[1]), .GAIN(gain_o[1]), .ADDR(addr[1]), .DATA(data[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int d, input int a, input int dat, input int wl);
        wr_rec_t r;
        r.d = d; r.addr = a; r.data = dat; r.wlen = wl;
        exp_wr.push_back(r);
    endtask

    task automatic push_txn(input int d, input int lat, input int csl, input int ldl);
        txn_rec_t t;
        t.d = d; t.lat = lat; t.cs_lo = csl; t.ldac_lo = ldl;
        exp_txn.push_back(t);
    endtask

    // Monitor: tracks each instance at the falling edge and checks completed
    // writes and transactions against the scoreboard queues.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                active[d]   = 0;
                rdy_next[d] = 0;
                wr_cnt[d]   = 0;
            end else begin
                if (active[d]) begin
                    since[d]++;
                    if (!cs[d])   cs_cnt[d]++;
                    if (!ldac[d]) ldac_cnt[d]++;
                    if (since[d] == 1) chk("ready_drop", ready[d], 0);
                    if (done[d]) begin
                        if (exp_txn.size() == 0) begin
                            chk("txn_unexpected", 1, 0);
                        end else begin
                            txn_rec_t t;
                            t = exp_txn.pop_front();
                            chk("txn_dut",     d,           t.d);
                            chk("done_lat",    since[d],    t.lat);
                            chk("cs_lo_cyc",   cs_cnt[d],   t.cs_lo);
                            chk("ldac_lo_cyc", ldac_cnt[d], t.ldac_lo);
                        end
                        active[d]   = 0;
                        rdy_next[d] = 1;
                    end else if (since[d] > 200) begin
                        chk("done_timeout", 0, 1);
                        active[d] = 0;
                    end
                end else begin
                    if (rdy_next[d]) begin
                        chk("ready_after_done", ready[d], 1);
                        rdy_next[d] = 0;
                    end
                    if (done[d]) chk("spurious_done", done[d], 0);
                end

                if (!wr[d]) begin
                    wr_cnt[d]++;
                end else if (wr_cnt[d] > 0) begin
                    if (exp_wr.size() == 0) begin
                        chk("write_unexpected", 1, 0);
                    end else begin
                        wr_rec_t r;
                        r = exp_wr.pop_front();
                        chk("write", {d[3:0], 6'(addr[d]), data[d], 8'(wr_cnt[d])},
                            {r.d[3:0], 6'(r.addr), 8'(r.data), 8'(r.wlen)});
                    end
                    wr_cnt[d] = 0;
                end

                if (start[d] && ready[d]) begin
                    active[d]   = 1;
                    since[d]    = 0;
                    cs_cnt[d]   = 0;
                    ldac_cnt[d] = 0;
                end
            end
        end
    end

    task automatic wait_done(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[d] && n < 200);
        if (!done[d]) chk("wait_done", 0, 1);
    endtask

    task automatic run_txn(input int d, input logic [31:0] dat, input logic [3:0] mask);
        int n;
        n = 0;
        while (!ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[d]) chk("wait_ready", 0, 1);
        @(posedge clk);
        #1;
        start[d] = 1; ch_data[d] = dat; ch_mask[d] = mask;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; the transaction must not see it.
        start[d] = 0; ch_data[d] = 32'hDEADBEEF; ch_mask[d] = 4'hF;
        wait_done(d);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int dsum;
        reset = 1; gain = 1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; pwr[d] = 0; clear[d] = 0; ch_data[d] = '0; ch_mask[d] = '0;
            active[d] = 0; rdy_next[d] = 0; since[d] = 0; wr_cnt[d] = 0;
            cs_cnt[d] = 0; ldac_cnt[d] = 0;
        end
        repeat (3) @(negedge clk);
        // {CS,WR,LDAC,CLR,PD,ready,done,ADDR,DATA}
        chk("reset_state0", {cs[0], wr[0], ldac[0], clr[0], pd[0], ready[0], done[0], addr[0], data[0]},
            {7'b1110000, 2'b00, 8'h00});
        chk("reset_state1", {cs[1], wr[1], ldac[1], clr[1], pd[1], ready[1], done[1], addr[1], data[1]},
            {7'b1110000, 2'b00, 8'h00});
        chk("gain_pass", gain_o[0], 1);

        @(posedge clk);
        #1;
        reset = 0; pwr[0] = 1; pwr[1] = 1;
        @(posedge clk);
        @(negedge clk);
        // INIT: {ready,CLR,PD,LDAC}
        chk("init0", {ready[0], clr[0], pd[0], ldac[0]}, 4'b0111);
        chk("init1", {ready[1], clr[1], pd[1], ldac[1]}, 4'b0110);
        @(negedge clk);
        chk("ready0_up", {ready[0], clr[0], pd[0], ldac[0]}, 4'b1111);
        chk("ready1_up", ready[1], 1);

        // Mode 0, four channels, one LDAC pulse, done at 18.
        push_wr(0, 0, 8'h11, 1); push_wr(0, 1, 8'h22, 1);
        push_wr(0, 2, 8'h33, 1); push_wr(0, 3, 8'h44, 1);
        push_txn(0, 18, 12, 1);
        run_txn(0, 32'h44332211, 4'hF);

        // Sparse mask 0101.
        push_wr(0, 0, 8'hDD, 1); push_wr(0, 2, 8'hBB, 1);
        push_txn(0, 10, 6, 1);
        run_txn(0, 32'hAABBCCDD, 4'b0101);

        // Empty mask: no bus activity, done 1 cycle after accept.
        push_txn(0, 1, 0, 0);
        run_txn(0, 32'h12345678, 4'h0);

        // Mode 1, WR_CYC=3, mask 1010: LDAC low throughout.
        push_wr(1, 1, 8'h22, 3); push_wr(1, 3, 8'h44, 3);
        push_txn(1, 13, 10, 13);
        run_txn(1, 32'h44332211, 4'b1010);

        // Mode 1, highest channel only.
        push_wr(1, 3, 8'h5A, 3);
        push_txn(1, 7, 5, 7);
        run_txn(1, 32'h5A000000, 4'b1000);

        // CLR pulse of 2 cycles on instance 1.
        @(posedge clk);
        #1;
        clear[1] = 1;
        @(posedge clk);
        #1;
        clear[1] = 0;
        @(negedge clk);
        chk("clear_c1", {clr[1], ready[1]}, 2'b00);
        @(negedge clk);
        chk("clear_c2", {clr[1], ready[1]}, 2'b00);
        @(negedge clk);
        chk("clear_end", {clr[1], ready[1]}, 2'b11);

        // start > ~pwr > clear, all asserted together on instance 0.
        push_wr(0, 0, 8'h77, 1);
        push_txn(0, 6, 3, 1);
        @(posedge clk);
        #1;
        start[0] = 1; ch_data[0] = 32'h00000077; ch_mask[0] = 4'h1; clear[0] = 1; pwr[0] = 0;
        @(posedge clk);
        #1;
        start[0] = 0;
        wait_done(0);
        @(negedge clk);
        chk("prio_ready_pd", {ready[0], pd[0]}, 2'b11);
        @(negedge clk);
        chk("prio_off", {ready[0], pd[0], clr[0]}, 3'b000);
        repeat (4) @(negedge clk);
        chk("clear_ignored_off", {ready[0], pd[0], clr[0]}, 3'b000);
        clear[0] = 0;

        // Reset during WR_LO on instance 1: asynchronous abort, no done.
        @(posedge clk);
        #1;
        start[1] = 1; ch_data[1] = 32'h00000099; ch_mask[1] = 4'h1;
        @(posedge clk);
        #1;
        start[1] = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr[1] && n < 20);
        chk("reach_wr_lo", wr[1], 0);
        #1;
        reset = 1;
        #1;
        chk("async_reset_pins", {cs[1], wr[1], ldac[1], clr[1], pd[1]}, 5'b11100);
        chk("async_reset_done", done[1], 0);
        pwr[1] = 0;
        dsum = 0;
        repeat (3) begin
            @(negedge clk);
            dsum += int'(done[1]);
        end
        @(posedge clk);
        #1;
        reset = 0;
        repeat (5) begin
            @(negedge clk);
            dsum += int'(done[1]);
        end
        chk("no_done_after_abort", dsum, 0);
        chk("off_after_abort", {pd[1], ready[1]}, 2'b00);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("txn_queue_empty", exp_txn.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
